lsu_dmem_ctrl: RTL

Load/store controller directly upstream of the load-extension stage. It accepts one load or store from execute, runs a valid/ack transaction on the data-memory port, and generates byte enables and replicated store data. For loads it right-justifies the addressed byte or halfword and returns it as raw memdata with the loadtype code, which the extension stage sign- or zero-extends. It stalls the pipeline through busy/req_ready while a transaction is outstanding.

---
 rtl/lsu_dmem_ctrl.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/lsu_dmem_ctrl.sv
// Load/store controller: one access at a time on a valid/ack dmem port, lane steering, right-justified load data. Optional: LSU_TIMEOUT_EN.
// Latency: dmem_req the cycle after accept, resp_valid the cycle after dmem_ack (illegal access: cycle after accept).
// Backpressure: req_ready only in IDLE; the requester holds req_valid while busy.
module lsu_dmem_ctrl #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_memdata,
  output logic [2:0]        resp_loadtype,
  output logic              resp_err,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_ACK, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [1:0]        off_q, off_d;
  logic              legal;
  logic              tmo_hit;
  logic [31:0]       lane_wdata;
  logic [3:0]        lane_be;

  logic              req_ready_d, busy_d, resp_valid_d, resp_err_d;
  logic [31:0]       resp_memdata_d;
  logic [2:0]        resp_loadtype_d;
  logic              dmem_req_d, dmem_we_d;
  logic [ADDR_W-1:0] dmem_addr_d;
  logic [31:0]       dmem_wdata_d;
  logic [3:0]        dmem_be_d;

  always_comb begin
    legal = 1'b0;
    case (req_funct3)
      3'b000:  legal = 1'b1;
      3'b001:  legal = ~req_addr[0];
      3'b010:  legal = (req_addr[1:0] == 2'b00);
      3'b100:  legal = ~req_we;
      3'b101:  legal = ~req_we & ~req_addr[0];
      default: legal = 1'b0;
    endcase
  end

  // Loads always fetch the full word; the addressed lanes are picked on return.
  always_comb begin
    lane_wdata = req_wdata;
    lane_be    = 4'b1111;
    if (req_we) begin
      case (req_funct3[1:0])
        2'b00: begin
          lane_wdata = {4{req_wdata[7:0]}};
          lane_be    = 4'b0001 << req_addr[1:0];
        end
        2'b01: begin
          lane_wdata = {2{req_wdata[15:0]}};
          lane_be    = 4'b0011 << req_addr[1:0];
        end
        default: begin
          lane_wdata = req_wdata;
          lane_be    = 4'b1111;
        end
      endcase
    end
  end

`ifdef LSU_TIMEOUT_EN
  localparam int TCW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [TCW-1:0] tmo_cnt;

  assign tmo_hit = (state_q == S_WAIT_ACK) && (tmo_cnt == TCW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset)
      tmo_cnt <= '0;
    else if (state_q != S_WAIT_ACK)
      tmo_cnt <= '0;
    else if (!dmem_ack)
      tmo_cnt <= tmo_cnt + 1'b1;
  end
`else
  localparam int TMO_UNUSED = TIMEOUT_CYCLES;
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d         = state_q;
    off_d           = off_q;
    resp_valid_d    = 1'b0;
    resp_err_d      = resp_err;
    resp_memdata_d  = resp_memdata;
    resp_loadtype_d = resp_loadtype;
    dmem_req_d      = dmem_req;
    dmem_we_d       = dmem_we;
    dmem_addr_d     = dmem_addr;
    dmem_wdata_d    = dmem_wdata;
    dmem_be_d       = dmem_be;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          off_d           = req_addr[1:0];
          resp_loadtype_d = req_funct3;
          if (legal) begin
            state_d      = S_WAIT_ACK;
            dmem_req_d   = 1'b1;
            dmem_we_d    = req_we;
            dmem_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
            dmem_wdata_d = lane_wdata;
            dmem_be_d    = lane_be;
          end else begin
            state_d        = S_RESP;
            resp_valid_d   = 1'b1;
            resp_err_d     = 1'b1;
            resp_memdata_d = 32'd0;
          end
        end
      end
      S_WAIT_ACK: begin
        if (dmem_ack) begin
          state_d        = S_RESP;
          dmem_req_d     = 1'b0;
          resp_valid_d   = 1'b1;
          resp_err_d     = 1'b0;
          resp_memdata_d = dmem_we ? 32'd0 : (dmem_rdata >> {off_q, 3'b000});
        end else if (tmo_hit) begin
          state_d        = S_RESP;
          dmem_req_d     = 1'b0;
          resp_valid_d   = 1'b1;
          resp_err_d     = 1'b1;
          resp_memdata_d = 32'd0;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    req_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      off_q         <= 2'b00;
      req_ready     <= 1'b1;
      busy          <= 1'b0;
      resp_valid    <= 1'b0;
      resp_err      <= 1'b0;
      resp_memdata  <= 32'd0;
      resp_loadtype <= 3'b000;
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= '0;
      dmem_wdata    <= 32'd0;
      dmem_be       <= 4'b0000;
    end else begin
      state_q       <= state_d;
      off_q         <= off_d;
      req_ready     <= req_ready_d;
      busy          <= busy_d;
      resp_valid    <= resp_valid_d;
      resp_err      <= resp_err_d;
      resp_memdata  <= resp_memdata_d;
      resp_loadtype <= resp_loadtype_d;
      dmem_req      <= dmem_req_d;
      dmem_we       <= dmem_we_d;
      dmem_addr     <= dmem_addr_d;
      dmem_wdata    <= dmem_wdata_d;
      dmem_be       <= dmem_be_d;
    end
  end

endmodule
